// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//
// Register file with a busy-bit scoreboard for the CPU datapath.
// It holds WIDTH x DEPTH storage, two combinational read ports, one write
// port and one reservation port. The reservation port marks a destination
// register busy between issue and writeback. Register 0 is hardwired to
// zero and is never busy.
//
// Parameters
//   WIDTH   data bits per register
//   DEPTH   number of registers (power of two, >= 2)
//
// Ports
//   clk           rising-edge clock for all state
//   rst           synchronous, active-high reset of data, busy bits and
//                 status outputs
//   SrcReg1/2     read addresses
//   SrcData1/2    combinational read data
//   Busy1/2       combinational busy bit of the read addresses
//   WriteReg      write enable; clears the busy bit of DstReg
//   DstReg        write address
//   DstData       write data
//   ResvReg       reservation enable; sets the busy bit of ResvAddr
//   ResvAddr      register to reserve
//   PendingCount  registered number of busy registers after the last edge
//   ResvConflict  registered; high for one cycle after a reservation found
//                 its register already busy
//
// Build option
//   REGFILE_BYPASS_EN  When defined, a write in progress forwards DstData
//                      to a read port that addresses the same register, and
//                      that port reports not-busy in the same cycle. When it
//                      is undefined, reads return stored state only.
//                      Sequential behaviour is the same in both builds.
// ---------------------------------------------------------------------------
module regfile_sb #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [$clog2(DEPTH)-1:0]   SrcReg1,
   input  logic [$clog2(DEPTH)-1:0]   SrcReg2,
   output logic [WIDTH-1:0]           SrcData1,
   output logic [WIDTH-1:0]           SrcData2,
   output logic                       Busy1,
   output logic                       Busy2,
   input  logic                       WriteReg,
   input  logic [$clog2(DEPTH)-1:0]   DstReg,
   input  logic [WIDTH-1:0]           DstData,
   input  logic                       ResvReg,
   input  logic [$clog2(DEPTH)-1:0]   ResvAddr,
   output logic [$clog2(DEPTH):0]     PendingCount,
   output logic                       ResvConflict
);

   localparam int ADDR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]  data [DEPTH];
   logic [DEPTH-1:0]  busy;

   logic              wr_en;
   logic              resv_en;
   logic [DEPTH-1:0]  busy_nxt;
   logic              conflict_nxt;
   logic [ADDR_W:0]   pending_nxt;

   // Number of set bits in a busy vector.
   function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
      logic [ADDR_W:0] cnt;
      cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt = cnt + (ADDR_W+1)'(v[i]);
      end
      return cnt;
   endfunction

   // Anything addressed at register 0 is dropped here, so nothing below
   // needs its own special case for it.
   assign wr_en   = WriteReg && (DstReg   != '0);
   assign resv_en = ResvReg  && (ResvAddr != '0);

   // Next busy vector. The reservation is applied after the write, so a
   // same-cycle write and reservation of one register leaves it busy: the
   // newly issued producer owns the register.
   always_comb begin
      busy_nxt = busy;
      if (wr_en) begin
         busy_nxt[DstReg] = 1'b0;
      end
      if (resv_en) begin
         busy_nxt[ResvAddr] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   // A conflict is a reservation of a register that is still busy after
   // this edge's writeback. A write retiring the old producer in the same
   // cycle clears the way, so that case is not a conflict.
   always_comb begin
      conflict_nxt = 1'b0;
      if (resv_en && busy[ResvAddr] && !(wr_en && (DstReg == ResvAddr))) begin
         conflict_nxt = 1'b1;
      end
   end

   assign pending_nxt = popcount(busy_nxt);

   // State update; reset dominates every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            data[i] <= '0;
         end
         busy         <= '0;
         PendingCount <= '0;
         ResvConflict <= 1'b0;
      end else begin
         if (wr_en) begin
            data[DstReg] <= DstData;
         end
         busy         <= busy_nxt;
         PendingCount <= pending_nxt;
         ResvConflict <= conflict_nxt;
      end
   end

   // Read ports. Register 0 is forced to zero here rather than relying on
   // its storage, which keeps it zero regardless of what the array holds.
`ifdef REGFILE_BYPASS_EN
   always_comb begin
      SrcData1 = (SrcReg1 == '0) ? '0 : data[SrcReg1];
      Busy1    = busy[SrcReg1];
      if (wr_en && (SrcReg1 == DstReg)) begin
         SrcData1 = DstData;
         Busy1    = 1'b0;
      end
   end

   always_comb begin
      SrcData2 = (SrcReg2 == '0) ? '0 : data[SrcReg2];
      Busy2    = busy[SrcReg2];
      if (wr_en && (SrcReg2 == DstReg)) begin
         SrcData2 = DstData;
         Busy2    = 1'b0;
      end
   end
`else
   always_comb begin
      SrcData1 = (SrcReg1 == '0) ? '0 : data[SrcReg1];
      Busy1    = busy[SrcReg1];
   end

   always_comb begin
      SrcData2 = (SrcReg2 == '0) ? '0 : data[SrcReg2];
      Busy2    = busy[SrcReg2];
   end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
//
// Directed bench for regfile_sb (WIDTH=16, DEPTH=16). Inputs change 1 time
// unit after a rising edge; outputs are sampled 1 time unit after inputs
// settle, away from the clock edge. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

   logic        clk;
   logic        rst;
   logic [3:0]  SrcReg1;
   logic [3:0]  SrcReg2;
   logic [15:0] SrcData1;
   logic [15:0] SrcData2;
   logic        Busy1;
   logic        Busy2;
   logic        WriteReg;
   logic [3:0]  DstReg;
   logic [15:0] DstData;
   logic        ResvReg;
   logic [3:0]  ResvAddr;
   logic [4:0]  PendingCount;
   logic        ResvConflict;

   int errors = 0;
   int checks = 0;

   regfile_sb #(.WIDTH(16), .DEPTH(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .SrcReg1      (SrcReg1),
      .SrcReg2      (SrcReg2),
      .SrcData1     (SrcData1),
      .SrcData2     (SrcData2),
      .Busy1        (Busy1),
      .Busy2        (Busy2),
      .WriteReg     (WriteReg),
      .DstReg       (DstReg),
      .DstData      (DstData),
      .ResvReg      (ResvReg),
      .ResvAddr     (ResvAddr),
      .PendingCount (PendingCount),
      .ResvConflict (ResvConflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst      = 1'b1;
      WriteReg = 1'b1;
      DstReg   = 4'd3;
      DstData  = 16'hBEEF;
      ResvReg  = 1'b0;
      ResvAddr = 4'd0;
      SrcReg1  = 4'd3;
      SrcReg2  = 4'd0;

      // Reset held two cycles while a write to R3 is attempted.
      tick();
      tick();
      WriteReg = 1'b0;
      #1;
      chk("reset_data3", {16'h0, SrcData1}, 32'h0);
      chk("reset_busy1", {31'h0, Busy1}, 32'h0);
      chk("reset_pending", {27'h0, PendingCount}, 32'h0);
      chk("reset_conflict", {31'h0, ResvConflict}, 32'h0);
      rst = 1'b0;

      // Writes to R5 and R7, then read both.
      WriteReg = 1'b1; DstReg = 4'd5; DstData = 16'h1234;
      tick();
      DstReg = 4'd7; DstData = 16'hABCD;
      tick();
      WriteReg = 1'b0;
      SrcReg1 = 4'd5; SrcReg2 = 4'd7;
      #1;
      chk("read_r5", {16'h0, SrcData1}, 32'h1234);
      chk("read_r7", {16'h0, SrcData2}, 32'hABCD);

      // Write to R0 is ignored.
      WriteReg = 1'b1; DstReg = 4'd0; DstData = 16'hFFFF;
      tick();
      WriteReg = 1'b0;
      SrcReg1 = 4'd0;
      #1;
      chk("read_r0", {16'h0, SrcData1}, 32'h0);
      chk("busy_r0", {31'h0, Busy1}, 32'h0);

      // Reserve R4 then R9.
      ResvReg = 1'b1; ResvAddr = 4'd4;
      tick();
      chk("pending_after_r4", {27'h0, PendingCount}, 32'd1);
      chk("conflict_after_r4", {31'h0, ResvConflict}, 32'h0);
      ResvAddr = 4'd9;
      tick();
      chk("pending_after_r9", {27'h0, PendingCount}, 32'd2);
      ResvReg = 1'b0;
      SrcReg1 = 4'd4; SrcReg2 = 4'd9;
      #1;
      chk("busy_r4", {31'h0, Busy1}, 32'h1);
      chk("busy_r9", {31'h0, Busy2}, 32'h1);

      // Writeback to R4 clears its busy bit.
      WriteReg = 1'b1; DstReg = 4'd4; DstData = 16'h0042;
      tick();
      WriteReg = 1'b0;
      #1;
      chk("wb_busy_r4", {31'h0, Busy1}, 32'h0);
      chk("wb_pending", {27'h0, PendingCount}, 32'd1);
      chk("wb_data_r4", {16'h0, SrcData1}, 32'h0042);

      // R6 busy, then simultaneous write and reservation of R6.
      ResvReg = 1'b1; ResvAddr = 4'd6;
      tick();
      chk("pending_r6", {27'h0, PendingCount}, 32'd2);
      WriteReg = 1'b1; DstReg = 4'd6; DstData = 16'h7777;
      tick();
      WriteReg = 1'b0; ResvReg = 1'b0;
      SrcReg1 = 4'd6;
      #1;
      chk("simul_data_r6", {16'h0, SrcData1}, 32'h7777);
      chk("simul_busy_r6", {31'h0, Busy1}, 32'h1);
      chk("simul_pending", {27'h0, PendingCount}, 32'd2);
      chk("simul_conflict", {31'h0, ResvConflict}, 32'h0);

      // Reserve R6 again while busy: conflict for exactly one cycle.
      ResvReg = 1'b1; ResvAddr = 4'd6;
      tick();
      ResvReg = 1'b0;
      chk("conflict_r6", {31'h0, ResvConflict}, 32'h1);
      chk("conflict_pending", {27'h0, PendingCount}, 32'd2);
      tick();
      chk("conflict_clears", {31'h0, ResvConflict}, 32'h0);

      // Reservation of R0 is ignored.
      ResvReg = 1'b1; ResvAddr = 4'd0;
      tick();
      ResvReg = 1'b0;
      chk("resv_r0_pending", {27'h0, PendingCount}, 32'd2);
      chk("resv_r0_conflict", {31'h0, ResvConflict}, 32'h0);

      // R2 busy, then write R2 with a same-cycle read of R2.
      ResvReg = 1'b1; ResvAddr = 4'd2;
      tick();
      ResvReg = 1'b0;
      chk("pending_r2", {27'h0, PendingCount}, 32'd3);
      WriteReg = 1'b1; DstReg = 4'd2; DstData = 16'h5A5A;
      SrcReg1 = 4'd2;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("bypass_data_r2", {16'h0, SrcData1}, 32'h5A5A);
      chk("bypass_busy_r2", {31'h0, Busy1}, 32'h0);
`else
      chk("nobypass_data_r2", {16'h0, SrcData1}, 32'h0);
      chk("nobypass_busy_r2", {31'h0, Busy1}, 32'h1);
`endif
      tick();
      WriteReg = 1'b0;
      #1;
      chk("after_wb_data_r2", {16'h0, SrcData1}, 32'h5A5A);
      chk("after_wb_busy_r2", {31'h0, Busy1}, 32'h0);
      chk("after_wb_pending", {27'h0, PendingCount}, 32'd2);

      // Three busy (R2, R6, R9), then reset mid-operation.
      ResvReg = 1'b1; ResvAddr = 4'd2;
      tick();
      ResvReg = 1'b0;
      chk("pre_reset_pending", {27'h0, PendingCount}, 32'd3);
      ResvReg = 1'b1; ResvAddr = 4'd9;
      rst = 1'b1;
      tick();
      rst = 1'b0; ResvReg = 1'b0;
      chk("midreset_pending", {27'h0, PendingCount}, 32'd0);
      chk("midreset_conflict", {31'h0, ResvConflict}, 32'h0);
      for (int i = 0; i < 16; i++) begin
         SrcReg1 = 4'(i);
         SrcReg2 = 4'(15 - i);
         #1;
         chk($sformatf("midreset_data_%0d", i), {16'h0, SrcData1}, 32'h0);
         chk($sformatf("midreset_busy_%0d", i), {30'h0, Busy1, Busy2}, 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with an integrated busy-bit scoreboard, the next-generation storage block for the CPU datapath. It replaces the per-bit storage-cell array with a behavioural WIDTH x DEPTH array. It provides two combinational read ports, one write port, and one reservation port that marks destination registers busy between issue and writeback. Register 0 is hardwired to zero.

## Interface
- WIDTH, 16, data bits per register
- DEPTH, 16, number of registers (power of two, >= 2)
- ADDR_W, $clog2(DEPTH), address width (localparam, derived)
- clk  in  1  global clock; all state updates on rising edge
- rst  in  1  reset; synchronous and active-high
- SrcReg1  in  ADDR_W  read port 1 address
- SrcReg2  in  ADDR_W  read port 2 address
- SrcData1  out  WIDTH  read port 1 data
- SrcData2  out  WIDTH  read port 2 data
- Busy1  out  1  busy bit of SrcReg1
- Busy2  out  1  busy bit of SrcReg2
- WriteReg  in  1  write enable
- DstReg  in  ADDR_W  write address
- DstData  in  WIDTH  write data
- ResvReg  in  1  reservation enable
- ResvAddr  in  ADDR_W  register to mark busy
- PendingCount  out  ADDR_W+1  registered count of busy registers
- ResvConflict  out  1  registered; 1 for one cycle after a reservation hit an already-busy register

## Operation
- State: data[DEPTH], busy[DEPTH], PendingCount, ResvConflict.
- Reads are combinational: SrcDataN = data[SrcRegN] and BusyN = busy[SrcRegN]. Address 0 always reads data 0 and busy 0.
- Write: when WriteReg=1 and DstReg!=0, data[DstReg] <= DstData and busy[DstReg] <= 0 at the edge. A write to a non-busy register updates data; busy stays 0.
- Reservation: when ResvReg=1 and ResvAddr!=0, busy[ResvAddr] <= 1.
  - If it was already busy, busy stays 1 and ResvConflict <= 1 for the next cycle. Otherwise ResvConflict <= 0.
- Simultaneous write and reservation to the same address: data is written and busy ends at 1 (the new producer wins). ResvConflict is not raised if the write was clearing that bit.
- Writes, reservations and conflicts to address 0 are ignored entirely.
- PendingCount <= popcount of next-state busy vector, so it always equals the number of set busy bits after the edge. Range is 0..DEPTH-1.
- Reset (rst=1 at edge) dominates all other inputs. Reset values:
  - all data 0, all busy 0
  - PendingCount 0, ResvConflict 0
  - read outputs therefore 0 from the cycle after reset
- Reset mid-operation discards all pending reservations; no state survives.

## Timing
- Read latency 0 (combinational from address to data and busy).
- Write-to-read latency 1 cycle without bypass: the value is visible on reads in the cycle after the write edge.
- Reservation-to-Busy latency 1 cycle.
- PendingCount and ResvConflict are valid 1 cycle after the causing edge.
- No handshake; the caller guarantees stable inputs around the rising edge.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When WriteReg=1, DstReg!=0 and SrcRegN==DstReg, SrcDataN = DstData and BusyN = 0 in the same cycle (write-through).
  - A same-cycle reservation of that address does not affect BusyN until the edge.
- REGFILE_BYPASS_EN undefined: reads return stored state only, and the caller must stall one cycle after a write.
- Sequential state behaviour is identical in both builds.

## Test plan
- Reset: rst=1 for 2 cycles with WriteReg=1, DstReg=3, DstData=16'hBEEF -> data[3] stays 0; SrcData1 (SrcReg1=3)=0; PendingCount=0; Busy1=0.
- Write/read: write 16'h1234 to R5, then 16'hABCD to R7. Set SrcReg1=5, SrcReg2=7 next cycle -> SrcData1=16'h1234 and SrcData2=16'hABCD. Write 16'hFFFF to R0 -> SrcReg1=0 reads 16'h0000.
- Scoreboard: ResvReg to R4 then R9 -> PendingCount 1 then 2, and Busy for R4 = 1. Write R4=16'h0042 -> Busy 0, PendingCount 1, data 16'h0042.
- Simultaneous: R6 busy, then WriteReg and ResvReg both to R6 in one cycle -> data updated, busy[6]=1, PendingCount unchanged, ResvConflict=0. Reserve R6 again -> ResvConflict=1 for exactly one cycle.
- Bypass, with REGFILE_BYPASS_EN: R2 busy; WriteReg=1, DstReg=2, DstData=16'h5A5A, SrcReg1=2 -> SrcData1=16'h5A5A and Busy1=0 in the same cycle. Without the macro -> old data and Busy1=1 that cycle.
- Reset mid-operation: 3 registers busy, PendingCount=3, then rst=1 for one cycle -> PendingCount=0, all Busy 0, all data 0.
